// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the synchronous FIFO
//
// Purpose: default word/address widths and the depth-from-address-width
//          helper used by sync_fifo and sync_fifo_mem.
package fifo_pkg;

    localparam int DEF_DATASIZE = 8;
    localparam int DEF_ADDRSIZE = 4;

    // Number of storage words addressed by an address of the given width.
    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - single-clock storage array with registered read port
//
// Purpose: FIFO word storage. The array itself is never reset; only the
//          read-data register is cleared so rdata is 0 after reset.
// Ports:
//   clk    - clock, all updates on rising edge
//   rst_n  - asynchronous active-low reset (read register only)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable, loads rdata from raddr
//   raddr  - read address
//   rdata  - registered read data, holds when re is low
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                re,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDRSIZE);

    logic [DATASIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy, threshold and sticky error flags
//
// Purpose: single-clock FIFO. Binary pointers one bit wider than the address
//          distinguish full from empty; all flags derive from registered
//          pointers only.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   winc, wdata              - write request and data
//   rinc                     - read request
//   err_clr                  - synchronous clear of overflow/underflow
//   rdata, rvalid            - registered read data, valid the cycle after a read
//   wfull, rempty            - full / empty flags
//   almost_full, almost_empty- threshold flags from count
//   count                    - occupancy 0..DEPTH
//   overflow, underflow      - sticky rejected-write / rejected-read flags
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATASIZE  = DEF_DATASIZE,
    parameter int ADDRSIZE  = DEF_ADDRSIZE,
    parameter int AFULL_TH  = fifo_depth(ADDRSIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    input  logic                err_clr,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = fifo_depth(ADDRSIZE);

    generate
        if (ADDRSIZE < 1) begin : g_bad_addrsize
            $error("sync_fifo: ADDRSIZE must be at least 1");
        end
        if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
            $error("sync_fifo: AFULL_TH must be in 1..DEPTH");
        end
        if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
            $error("sync_fifo: AEMPTY_TH must be in 0..DEPTH-1");
        end
    endgenerate

    // Thresholds narrowed to count width; legal ranges always fit.
    localparam logic [ADDRSIZE:0] AF_LVL = AFULL_TH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] AE_LVL = AEMPTY_TH[ADDRSIZE:0];

    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic              wr_ok;
    logic              rd_ok;

    assign rempty = (wptr == rptr);
    // Same slot, different lap: writer is exactly DEPTH ahead.
    assign wfull  = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                    (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
    assign count  = wptr - rptr;

    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    // Acceptance uses the pre-edge flags, so full+read+write rejects the
    // write and empty+read+write rejects the read.
    assign wr_ok = winc && !wfull;
    assign rd_ok = rinc && !rempty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            rvalid <= rd_ok;
            // A new error in the same cycle as err_clr wins.
            overflow  <= (winc && wfull)  || (overflow  && !err_clr);
            underflow <= (rinc && rempty) || (underflow && !err_clr);
        end
    end

    // A read and write in the same cycle never share an address: that would
    // need the FIFO to be both non-empty and non-full with equal low bits.
    sync_fifo_mem #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wptr[ADDRSIZE-1:0]),
        .wdata (wdata),
        .re    (rd_ok),
        .raddr (rptr[ADDRSIZE-1:0]),
        .rdata (rdata)
    );

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATASIZE, default 8, width of each stored word in bits.
REQ-002 Parameter ADDRSIZE, default 4, address width; DEPTH = 2**ADDRSIZE words.
REQ-003 Parameter AFULL_TH, default DEPTH-2, occupancy at or above which almost_full asserts; legal range 1..DEPTH.
REQ-004 Parameter AEMPTY_TH, default 2, occupancy at or below which almost_empty asserts; legal range 0..DEPTH-1.
REQ-005 Single clock, clk; reset rst_n is asynchronous and active-low.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 winc  input  1  write request.
REQ-009 wdata  input  DATASIZE  write data, sampled with winc.
REQ-010 rinc  input  1  read request.
REQ-011 err_clr  input  1  synchronous clear of sticky overflow/underflow.
REQ-012 rdata  output  DATASIZE  registered read data.
REQ-013 rvalid  output  1  rdata updated this cycle.
REQ-014 wfull, rempty  output  1 each  full / empty flags.
REQ-015 almost_full, almost_empty  output  1 each  threshold flags.
REQ-016 count  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Write accepted iff winc && !wfull; stores wdata at waddr, waddr increments.
REQ-019 Read accepted iff rinc && !rempty; raddr increments.
REQ-020 Pointers wptr/rptr ADDRSIZE+1 bits, binary, wrap modulo 2*DEPTH; low ADDRSIZE bits address storage.
REQ-021 rempty = (wptr == rptr); wfull = MSBs differ and low bits equal; both derived from registered pointers only.
REQ-022 count = wptr - rptr modulo 2**(ADDRSIZE+1); never exceeds DEPTH.
REQ-023 Read latency 1: rdata takes word at raddr on edge accepting read; rvalid high exactly that following cycle, else 0; rdata holds otherwise.
REQ-024 Written word readable (rempty low) the cycle after write edge; no write-to-read bypass.
REQ-025 Simultaneous accepted read and write: both pointers advance, count unchanged.
REQ-026 Full + winc + rinc: read accepted, write rejected, overflow set; wfull deasserts next cycle.
REQ-027 Empty + winc + rinc: write accepted, read rejected, underflow set, rvalid stays 0.
REQ-028 Rejected write (winc && wfull) sets overflow; rejected read (rinc && rempty) sets underflow; storage and pointers unchanged.
REQ-029 overflow/underflow remain set until err_clr or reset; err_clr concurrent with new error leaves flag set.
REQ-030 almost_full = (count >= AFULL_TH); almost_empty = (count <= AEMPTY_TH); combinational from count.
REQ-031 Illegal AFULL_TH/AEMPTY_TH or ADDRSIZE < 1 shall halt elaboration with an error.

Reset
REQ-032 rst_n low asynchronously: wptr=rptr=0, rdata=0, rvalid=0, overflow=underflow=0.
REQ-033 During/after reset: rempty=1, wfull=0, count=0, almost_empty=1, almost_full=0.
REQ-034 Storage array not reset; contents after reset undefined and unobservable (empty).
REQ-035 Reset mid-operation discards all stored words; first post-reset write lands at address 0.

Structure
REQ-036 Shared package fifo_pkg holds default DATASIZE/ADDRSIZE constants and a depth-from-address-width function.
REQ-037 Storage in one sub-module sync_fifo_mem: single clock, write port with enable, registered read port with enable; no reset on array.
REQ-038 Pointer, flag, count and error logic in sync_fifo top.

Verification (DATASIZE=8, ADDRSIZE=4, AFULL_TH=14, AEMPTY_TH=2)
REQ-039 Reset, write 0x01..0x10 (16 words) -> wfull=1 after 16th, count=16, almost_full from count=14; read 16 -> 0x01..0x10 in order, rvalid each, rempty=1 at end.
REQ-040 Fill to 16, winc+rinc same cycle -> overflow=1, read returns head, count=15, wfull=0 next cycle.
REQ-041 Empty, winc+rinc with 0xA5 -> underflow=1, rvalid=0, count=1; next rinc -> rdata=0xA5.
REQ-042 Steady concurrent read/write for 40 cycles at count=8 -> count stays 8, pointers wrap twice, data order preserved.
REQ-043 Write 5 words, assert rst_n low mid-cycle -> outputs reset immediately; post-reset write 0x3C then read -> 0x3C.
REQ-044 Set overflow, pulse err_clr -> overflow=0 next cycle; err_clr with simultaneous rejected write -> overflow remains 1.
